fixed_requant: RTL and testbench
================================

# fixed_requant

Multi-channel, pipelined requantiser for the fixed-point control datapath. It arithmetic-shifts each lane right by a per-beat amount, optionally rounds, saturates to a narrower signed width and reports saturation events. It sits between the wide MAC/accumulator outputs and the 16-bit actuator/PWM command registers, replacing the combinational saturator on paths that need rescaling and backpressure.

## Interface
Parameters:
- `N_CH`, 4, number of independent lanes sharing one handshake
- `IN_W`, 32, signed input width per lane
- `OUT_W`, 16, signed output width per lane, `2 <= OUT_W <= IN_W`
- `SH_W`, 5, shift-amount width; legal shifts 0..IN_W-1
- `CNT_W`, 16, saturation event counter width (only with counters enabled)

Ports:
- `clk`, in, 1, sole clock, rising edge
- `rst`, in, 1, reset: synchronous, active-high
- `in_valid`, in, 1, input beat valid
- `in_ready`, out, 1, block can accept a beat
- `in_data`, in, N_CH*IN_W, lane k at bits [k*IN_W +: IN_W], signed
- `in_shamt`, in, SH_W, right-shift amount, travels with the beat
- `in_rnd`, in, 1, 0 = truncate (floor), 1 = round half up; travels with the beat
- `out_valid`, out, 1, output beat valid
- `out_ready`, in, 1, downstream accepts
- `out_data`, out, N_CH*OUT_W, lane k at [k*OUT_W +: OUT_W], signed
- `out_sat`, out, N_CH, per-lane flag: this beat's lane was clipped
- `sat_sticky`, out, N_CH, per-lane sticky clip flag
- `sat_clr`, in, 1, clears `sat_sticky` (and counters when enabled)
- `sat_cnt`, out, N_CH*CNT_W, per-lane clip counters (present only with `FIXED_REQUANT_SATCNT_EN`)

## Operation
- Per lane, stage 1: if `in_rnd`=1 and shamt>0, add 2^(shamt-1) in IN_W+1 bits, then arithmetic shift right by shamt; else arithmetic shift only (floor toward -inf). The result is IN_W+1 bits wide; the rounding add must never wrap.
- Stage 2: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. `out_sat[k]`=1 iff clamping changed the value. Rounding-induced overflow counts as saturation.
- `in_shamt` >= IN_W is illegal; the block treats it as IN_W-1. Assertion in sim.
- Sticky: on each output handshake (`out_valid && out_ready`), `sat_sticky[k]` |= `out_sat[k]`. `sat_clr` clears it; when clear and a set occur in the same cycle, the set wins (the flag ends 1).
- All lanes share one handshake; lanes never diverge in timing.

## Timing
- Two register stages; latency 2 cycles from input handshake to `out_valid` with no stall.
- Stage advance: s2 loads when `!s2_valid || out_ready`; s1 loads when `!s1_valid || s2 loads`. `in_ready` = `!s1_valid || s2 loads` (combinational from `out_ready`).
- Full throughput, 1 beat/cycle, when `out_ready` held high; no bubbles inserted.
- While `out_valid && !out_ready`, `out_data`/`out_sat` hold stable. At most 2 beats in flight, with no loss or reorder.
- Reset: `s1_valid`, `out_valid` = 0; `out_data`, `out_sat`, `sat_sticky`, `sat_cnt` = 0; `in_ready` = 1 in the cycle after reset deasserts. Reset mid-stream drops the in-flight beats.

## Configuration
- `FIXED_REQUANT_SATCNT_EN` defined: `sat_cnt` port exists. Per lane, increment by 1 on each handshake with `out_sat[k]`; saturate at 2^CNT_W-1 (no wrap). `sat_clr` zeroes it; clear and increment in the same cycle yields 1.
- Undefined: no `sat_cnt` port and no counter flops; everything else is identical.

## Structure
- Shared package `fixed_pkg`: OUT_MAX/OUT_MIN computation functions, the rounding-mode enum (`RND_TRUNC`, `RND_HALF_UP`) and the lane-packing helper.
- One sub-module, `requant_lane`: the per-lane round/shift/clamp datapath registered in both stages. It is instantiated N_CH times by generate; the top holds the handshake control and the sticky/counter logic.

## Test plan
- shamt=0, rnd=0: lanes 40000, -40000, 32767, -32768 -> 32767, -32768, 32767, -32768; out_sat = 1,1,0,0.
- shamt=4: in 24 -> 1 (rnd=0) / 2 (rnd=1); in -24 -> -2 (rnd=0) / -1 (rnd=1); out_sat = 0.
- shamt=4, rnd=1, in 524280 -> rounds to 32768 -> out 32767 with out_sat=1; with rnd=0 -> 32767, out_sat=0.
- Backpressure: push 6 beats back-to-back with out_ready low for 3 cycles -> in_ready drops after 2 accepted beats; all 6 emerge in order, data stable while stalled.
- sat_clr asserted in the same cycle as a saturating handshake -> sat_sticky stays 1; counter (if enabled) = 1. Drive 2^CNT_W+3 clips -> counter holds at max.
- Assert rst with 2 beats in flight -> next cycle out_valid=0, sticky/counters 0, in_ready=1; the next beat passes with 2-cycle latency.

Source files
------------

// File: rtl/fixed_pkg.sv
// fixed_pkg: shared types and helpers for the fixed-point requantiser.
// Clamp bounds, rounding-mode encoding and lane bit-offset helper.
package fixed_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

    function automatic longint out_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint out_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: one lane of round/shift (stage 1) and clamp (stage 2).
// Both stages are registered; load enables come from the shared handshake.
module requant_lane
    import fixed_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SH_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld1,
    input  logic             i_ld2,
    input  logic [IN_W-1:0]  i_data,
    input  logic [SH_W-1:0]  i_shamt,
    input  logic             i_rnd,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);

    localparam logic signed [IN_W:0] MAX = (IN_W+1)'(out_max(OUT_W));
    localparam logic signed [IN_W:0] MIN = (IN_W+1)'(out_min(OUT_W));
    localparam logic [SH_W-1:0] SH_LIM = SH_W'(IN_W - 1);

    logic [SH_W-1:0]      w_sh;
    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_half;
    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shr;
    logic                 w_hi;
    logic                 w_lo;
    logic                 w_rnd_on;

    logic signed [IN_W:0] r_s1;
    logic [OUT_W-1:0]     r_data;
    logic                 r_sat;

    // Out-of-range shift amounts saturate to the widest legal shift.
    assign w_sh     = (32'(i_shamt) >= 32'(IN_W)) ? SH_LIM : i_shamt;
    assign w_ext    = {i_data[IN_W-1], i_data};
    assign w_half   = (IN_W+1)'(1) << (w_sh - 1'b1);
    assign w_rnd_on = (rnd_mode_e'(i_rnd) == RND_HALF_UP) && (w_sh != '0);
    // One extra bit of headroom keeps the rounding add from wrapping.
    assign w_sum    = w_rnd_on ? (w_ext + w_half) : w_ext;
    assign w_shr    = w_sum >>> w_sh;

    assign w_hi = r_s1 > MAX;
    assign w_lo = r_s1 < MIN;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_data <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (i_ld1) begin
                r_s1 <= w_shr;
            end
            if (i_ld2) begin
                r_data <= w_hi ? MAX[OUT_W-1:0] :
                          w_lo ? MIN[OUT_W-1:0] :
                          r_s1[OUT_W-1:0];
                r_sat  <= w_hi | w_lo;
            end
        end
    end

    assign o_data = r_data;
    assign o_sat  = r_sat;

endmodule

// File: rtl/fixed_requant.sv
// fixed_requant: N_CH-lane 2-stage requantiser with shared valid/ready.
// Define FIXED_REQUANT_SATCNT_EN to add per-lane saturation counters.
module fixed_requant
    import fixed_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SH_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*IN_W-1:0]  in_data,
    input  logic [SH_W-1:0]       in_shamt,
    input  logic                  in_rnd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*OUT_W-1:0] out_data,
    output logic [N_CH-1:0]       out_sat,
    output logic [N_CH-1:0]       sat_sticky,
    input  logic                  sat_clr
`ifdef FIXED_REQUANT_SATCNT_EN
    ,
    output logic [N_CH*CNT_W-1:0] sat_cnt
`endif
);

    if ((OUT_W < 2) || (OUT_W > IN_W) || (CNT_W < 1)) begin : g_bad_cfg
        $error("fixed_requant: illegal parameter set");
    end

    logic            r_s1_valid;
    logic            r_s2_valid;
    logic [N_CH-1:0] r_sticky;
    logic            w_ld1;
    logic            w_ld2;
    logic            w_hs;
    logic            w_ld1_lane;
    logic            w_ld2_lane;
    logic [N_CH-1:0] w_sat;

    assign w_ld2      = !r_s2_valid || out_ready;
    assign w_ld1      = !r_s1_valid || w_ld2;
    assign w_hs       = r_s2_valid && out_ready;
    assign w_ld1_lane = w_ld1 && in_valid;
    assign w_ld2_lane = w_ld2 && r_s1_valid;

    assign in_ready   = w_ld1;
    assign out_valid  = r_s2_valid;
    assign out_sat    = w_sat;
    assign sat_sticky = r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_ld2) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_ld1) begin
                r_s1_valid <= in_valid;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        requant_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .SH_W  (SH_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_ld1   (w_ld1_lane),
            .i_ld2   (w_ld2_lane),
            .i_data  (in_data[lane_lsb(k, IN_W) +: IN_W]),
            .i_shamt (in_shamt),
            .i_rnd   (in_rnd),
            .o_data  (out_data[lane_lsb(k, OUT_W) +: OUT_W]),
            .o_sat   (w_sat[k])
        );
    end

    // A set in the same cycle as a clear still leaves the flag high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (sat_clr ? '0 : r_sticky) | (w_hs ? w_sat : '0);
        end
    end

`ifdef FIXED_REQUANT_SATCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH*CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (sat_clr) begin
                    r_cnt[k*CNT_W +: CNT_W] <= CNT_W'(w_hs && w_sat[k]);
                end else if (w_hs && w_sat[k] &&
                             (r_cnt[k*CNT_W +: CNT_W] != CNT_MAX)) begin
                    r_cnt[k*CNT_W +: CNT_W] <= r_cnt[k*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end

    assign sat_cnt = r_cnt;
`endif

    a_shamt_legal: assert property (@(posedge clk) disable iff (rst)
        (in_valid && w_ld1) |-> (32'(in_shamt) < 32'(IN_W)));

endmodule

// File: tb/tb_fixed_requant.sv
// tb_fixed_requant: randomized and directed checks of fixed_requant
// against an arithmetic reference model with a scoreboard.
module tb_fixed_requant;

    localparam int N_CH  = 4;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SH_W  = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [N_CH*OUT_W-1:0] d;
        logic [N_CH-1:0]       s;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_CH*IN_W-1:0]  in_data;
    logic [SH_W-1:0]       in_shamt;
    logic                  in_rnd;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_CH*OUT_W-1:0] out_data;
    logic [N_CH-1:0]       out_sat;
    logic [N_CH-1:0]       sat_sticky;
    logic                  sat_clr;
`ifdef FIXED_REQUANT_SATCNT_EN
    logic [N_CH*CNT_W-1:0] sat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fixed_requant #(
        .N_CH (N_CH), .IN_W (IN_W), .OUT_W (OUT_W),
        .SH_W (SH_W), .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_rnd     (in_rnd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky),
        .sat_clr    (sat_clr)
`ifdef FIXED_REQUANT_SATCNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic beat_t ref_beat(input logic [N_CH*IN_W-1:0] d,
                                       input logic [SH_W-1:0] sh_in,
                                       input logic rnd);
        beat_t b;
        longint x, den, q, hi, lo;
        int sh;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        sh = (int'(sh_in) >= IN_W) ? IN_W - 1 : int'(sh_in);
        den = longint'(1) << sh;
        b = '0;
        for (int k = 0; k < N_CH; k++) begin
            x = longint'($signed(d[k*IN_W +: IN_W]));
            if (rnd && sh > 0) x = x + den / 2;
            q = x / den;
            if ((x % den != 0) && (x < 0)) q = q - 1;
            b.s[k] = (q > hi) || (q < lo);
            if (q > hi) q = hi;
            else if (q < lo) q = lo;
            b.d[k*OUT_W +: OUT_W] = q[OUT_W-1:0];
        end
        return b;
    endfunction

    function automatic logic [N_CH*IN_W-1:0] pack_in(input longint a,
        input longint b, input longint c, input longint e);
        logic [N_CH*IN_W-1:0] v;
        v = '0;
        v[0*IN_W +: IN_W] = IN_W'(a);
        v[1*IN_W +: IN_W] = IN_W'(b);
        v[2*IN_W +: IN_W] = IN_W'(c);
        v[3*IN_W +: IN_W] = IN_W'(e);
        return v;
    endfunction

    function automatic logic [N_CH*OUT_W-1:0] pack_out(input longint a,
        input longint b, input longint c, input longint e);
        logic [N_CH*OUT_W-1:0] v;
        v = '0;
        v[0*OUT_W +: OUT_W] = OUT_W'(a);
        v[1*OUT_W +: OUT_W] = OUT_W'(b);
        v[2*OUT_W +: OUT_W] = OUT_W'(c);
        v[3*OUT_W +: OUT_W] = OUT_W'(e);
        return v;
    endfunction

    function automatic logic [IN_W-1:0] rnd_val();
        logic [IN_W-1:0] ex [4];
        ex[0] = 32'h7fffffff;
        ex[1] = 32'h80000000;
        ex[2] = 32'h0007fff8;
        ex[3] = 32'hfff80008;
        case ($urandom_range(0, 3))
            0: return IN_W'($urandom);
            1: return IN_W'(int'($urandom_range(0, 200000)) - 100000);
            2: return ex[$urandom_range(0, 3)];
            default: return IN_W'(int'($urandom_range(0, 80000)) - 40000);
        endcase
    endfunction

    // Scoreboard: expected beats queued at input handshake, retired at output.
    beat_t exp_q[$];
    beat_t exp_done[$];
    beat_t obs_q[$];
    logic [N_CH-1:0] m_sticky = '0;
    int m_cnt [N_CH];
    int spurious = 0;

    bit    p_rst = 1'b1;
    bit    p_in, p_out, p_clr;
    beat_t p_in_b, p_obs;

    initial forever begin
        @(negedge clk);
        p_rst  = rst;
        p_in   = in_valid && in_ready;
        p_out  = out_valid && out_ready;
        p_clr  = sat_clr;
        p_in_b = ref_beat(in_data, in_shamt, in_rnd);
        p_obs  = {out_data, out_sat};
    end

    initial begin
        for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
        forever begin
            logic [N_CH-1:0] set;
            beat_t e;
            @(posedge clk);
            set = '0;
            if (p_rst) begin
                exp_q.delete();
                m_sticky = '0;
                for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
            end else begin
                if (p_out) begin
                    if (exp_q.size() == 0) begin
                        spurious++;
                    end else begin
                        e = exp_q.pop_front();
                        exp_done.push_back(e);
                        obs_q.push_back(p_obs);
                        set = e.s;
                    end
                end
                if (p_in) exp_q.push_back(p_in_b);
                m_sticky = (p_clr ? '0 : m_sticky) | set;
                for (int k = 0; k < N_CH; k++) begin
                    if (p_clr) m_cnt[k] = set[k] ? 1 : 0;
                    else if (set[k] && m_cnt[k] < CMAX) m_cnt[k]++;
                end
            end
        end
    end

    function automatic logic [N_CH*CNT_W-1:0] model_cnt();
        logic [N_CH*CNT_W-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        return v;
    endfunction

    task automatic flush();
        obs_q.delete();
        exp_done.delete();
    endtask

    task automatic send(input logic [N_CH*IN_W-1:0] d,
                        input logic [SH_W-1:0] sh,
                        input logic r, output bit ok);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_rnd   = r;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic measure(input logic [N_CH*IN_W-1:0] d,
                           input logic [SH_W-1:0] sh, input logic r,
                           output int lat, output beat_t seen);
        lat = 0;
        seen = '0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_rnd   = r;
        @(negedge clk);
        if (!in_ready) lat = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                seen = {out_data, out_sat};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        checks++;
        if (out_data !== '0 || out_sat !== '0 || sat_sticky !== '0) begin
            errors++;
            $display("FAIL reset_regs got d=%h s=%b st=%b want 0",
                     out_data, out_sat, sat_sticky);
        end
`ifdef FIXED_REQUANT_SATCNT_EN
        checks++;
        if (sat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0", sat_cnt);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_sat_clip();
        bit ok, ok2;
        flush();
        out_ready = 1'b1;
        send(pack_in(40000, -40000, 32767, -32768), 0, 1'b0, ok);
        drain(ok2);
        checks++;
        if (!ok || !ok2 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL clip_count got %0d beats want 1", obs_q.size());
        end
        checks++;
        if (obs_q[0].d !== pack_out(32767, -32768, 32767, -32768)) begin
            errors++;
            $display("FAIL clip_data got %h want %h", obs_q[0].d,
                     pack_out(32767, -32768, 32767, -32768));
        end
        checks++;
        if (obs_q[0].s !== 4'b0011) begin
            errors++;
            $display("FAIL clip_sat got %b want 0011", obs_q[0].s);
        end
    endtask

    task automatic test_round();
        bit ok, ok2, ok3;
        logic [N_CH*IN_W-1:0] d;
        d = pack_in(24, -24, 524280, 32'sh80000000);
        flush();
        out_ready = 1'b1;
        send(d, 4, 1'b0, ok);
        send(d, 4, 1'b1, ok2);
        drain(ok3);
        checks++;
        if (!ok || !ok2 || !ok3 || obs_q.size() != 2) begin
            errors++;
            $display("FAIL round_count got %0d beats want 2", obs_q.size());
        end
        checks++;
        if (obs_q[0] !== {pack_out(1, -2, 32767, -32768), 4'b1000}) begin
            errors++;
            $display("FAIL round_trunc got %h/%b want %h/1000", obs_q[0].d,
                     obs_q[0].s, pack_out(1, -2, 32767, -32768));
        end
        checks++;
        if (obs_q[1] !== {pack_out(2, -1, 32767, -32768), 4'b1100}) begin
            errors++;
            $display("FAIL round_half got %h/%b want %h/1100", obs_q[1].d,
                     obs_q[1].s, pack_out(2, -1, 32767, -32768));
        end
    endtask

    task automatic test_latency();
        int lat;
        beat_t seen;
        bit ok;
        flush();
        out_ready = 1'b1;
        measure(pack_in(100, -100, 0, 7), 1, 1'b1, lat, seen);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL latency got %0d want 2", lat);
        end
        checks++;
        if (seen !== {pack_out(50, -50, 0, 4), 4'b0000}) begin
            errors++;
            $display("FAIL latency_data got %h/%b want %h/0000", seen.d,
                     seen.s, pack_out(50, -50, 0, 4));
        end
        drain(ok);
    endtask

    task automatic test_back_to_back();
        logic [N_CH*IN_W-1:0] bd [6];
        logic [SH_W-1:0] bs [6];
        logic br [6];
        logic [N_CH*OUT_W-1:0] hold;
        logic [N_CH-1:0] hsat;
        int idx;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N_CH; k++) bd[i][k*IN_W +: IN_W] = rnd_val();
            bs[i] = SH_W'($urandom);
            br[i] = 1'($urandom);
        end
        flush();
        idx = 0;
        hold = '0;
        hsat = '0;
        for (int c = 0; c < 40 && !(idx == 6 && exp_q.size() == 0); c++) begin
            out_ready = (c >= 4);
            in_valid  = (idx < 6);
            if (idx < 6) begin
                in_data  = bd[idx];
                in_shamt = bs[idx];
                in_rnd   = br[idx];
            end
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (idx != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_fill got acc=%0d rdy=%b v=%b want 2/0/1",
                             idx, in_ready, out_valid);
                end
                hold = out_data;
                hsat = out_sat;
            end
            if (c == 3) begin
                checks++;
                if (out_data !== hold || out_sat !== hsat || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stable got %h/%b want %h/%b",
                             out_data, out_sat, hold, hsat);
                end
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (idx != 6 || obs_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count got acc=%0d out=%0d want 6/6", idx, obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 6; i++) begin
            checks++;
            if (obs_q[i] !== ref_beat(bd[i], bs[i], br[i])) begin
                errors++;
                $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i],
                         ref_beat(bd[i], bs[i], br[i]));
            end
        end
    endtask

    task automatic test_sticky_clr();
        bit ok;
        out_ready = 1'b1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (sat_sticky !== '0) begin
            errors++;
            $display("FAIL clr_only got %b want 0000", sat_sticky);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(pack_in(40000, 0, 0, 0), 0, 1'b0, ok);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (sat_sticky !== 4'b0001) begin
            errors++;
            $display("FAIL clr_vs_set got %b want 0001", sat_sticky);
        end
`ifdef FIXED_REQUANT_SATCNT_EN
        checks++;
        if (sat_cnt !== pack_cnt(1, 0, 0, 0)) begin
            errors++;
            $display("FAIL cnt_clr_set got %h want %h", sat_cnt, pack_cnt(1, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            send(pack_in(40000, -40000, 5, 0), 0, 1'b0, ok);
        end
        drain(ok);
        @(negedge clk);
        checks++;
        if (sat_cnt !== pack_cnt(CMAX, CMAX, 0, 0)) begin
            errors++;
            $display("FAIL cnt_hold got %h want %h", sat_cnt, pack_cnt(CMAX, CMAX, 0, 0));
        end
`endif
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_CH*CNT_W-1:0] pack_cnt(input int a,
        input int b, input int c, input int e);
        logic [N_CH*CNT_W-1:0] v;
        v[0*CNT_W +: CNT_W] = CNT_W'(a);
        v[1*CNT_W +: CNT_W] = CNT_W'(b);
        v[2*CNT_W +: CNT_W] = CNT_W'(c);
        v[3*CNT_W +: CNT_W] = CNT_W'(e);
        return v;
    endfunction

    task automatic test_random();
        bit accepted, ok;
        int n_acc;
        flush();
        n_acc = 0;
        accepted = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < N_CH; k++) in_data[k*IN_W +: IN_W] = rnd_val();
                in_shamt = SH_W'($urandom);
                in_rnd   = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr   = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            accepted = in_valid && in_ready;
            if (accepted) n_acc++;
            checks++;
            if (sat_sticky !== m_sticky) begin
                errors++;
                $display("FAIL rand_sticky c%0d got %b want %b", c, sat_sticky, m_sticky);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        sat_clr  = 1'b0;
        drain(ok);
        checks++;
        if (!ok || obs_q.size() != n_acc || spurious != 0) begin
            errors++;
            $display("FAIL rand_count got %0d (+%0d extra) want %0d",
                     obs_q.size(), spurious, n_acc);
        end
        for (int i = 0; i < obs_q.size() && i < exp_done.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_done[i]) begin
                errors++;
                $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i], exp_done[i]);
            end
        end
`ifdef FIXED_REQUANT_SATCNT_EN
        @(negedge clk);
        checks++;
        if (sat_cnt !== model_cnt()) begin
            errors++;
            $display("FAIL rand_cnt got %h want %h", sat_cnt, model_cnt());
        end
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset_midstream();
        bit ok, ok2, ok3;
        int lat;
        beat_t seen;
        out_ready = 1'b1;
        send(pack_in(40000, 0, 0, 0), 0, 1'b0, ok);
        drain(ok);
        out_ready = 1'b0;
        send(pack_in(40000, 1, 2, 3), 0, 1'b0, ok);
        send(pack_in(4, 5, 6, 7), 0, 1'b0, ok2);
        checks++;
        if (!ok || !ok2 || out_valid !== 1'b1 || sat_sticky[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill got acc=%b%b v=%b st=%b want 11/1/xxx1",
                     ok, ok2, out_valid, sat_sticky);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_sticky !== '0) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%b st=%b want 0/1/0000",
                     out_valid, in_ready, sat_sticky);
        end
`ifdef FIXED_REQUANT_SATCNT_EN
        checks++;
        if (sat_cnt !== '0) begin
            errors++;
            $display("FAIL mid_cnt got %h want 0", sat_cnt);
        end
`endif
        @(posedge clk);
        #1;
        flush();
        out_ready = 1'b1;
        measure(pack_in(-7, 9, 131072, 0), 2, 1'b0, lat, seen);
        checks++;
        if (lat != 2 || seen !== {pack_out(-2, 2, 32767, 0), 4'b0100}) begin
            errors++;
            $display("FAIL mid_next got lat=%0d %h/%b want 2 %h/0100",
                     lat, seen.d, seen.s, pack_out(-2, 2, 32767, 0));
        end
        drain(ok3);
        checks++;
        if (!ok3 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL mid_drain got %0d beats want 1", obs_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_rnd    = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        test_reset();
        test_sat_clip();
        test_round();
        test_latency();
        test_back_to_back();
        test_sticky_clr();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
